// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer sharing one external combinational adder among NREQ requesters.
// Optional per-requester grant counters enabled by defining ADDER_ARB_STATS_EN.
module adder_rr_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  input  logic [N-1:0]      add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0] grant_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] idx;
  logic           grant_found;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;

  // Search starts at rr_ptr; IDW-bit addition wraps modulo NREQ since NREQ is a power of 2.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = rr_ptr + IDW'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found)
      req_ready[grant_id] = 1'b1;
  end

  assign add_a = op_a;
  assign add_b = op_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= grant_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt <= '0;
      else if ((state == IDLE) && grant_found && (grant_id == IDW'(g)) && (cnt != 8'hFF))
        cnt <= cnt + 8'd1;
    end
    assign grant_cnt[g*8 +: 8] = cnt;
  end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: vector table, corner sequences, random vs. transaction model.
// Exercises the grant counters too when ADDER_ARB_STATS_EN is defined.
module tb_adder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic        rsp_cout;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The shared adder lives outside the arbiter.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  adder_rr_arbiter #(.N(16), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset_ready", req_ready, 0);
    rst_n = 1'b1; req_valid = '0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_add_a", add_a, 0);
    chk("reset_add_b", add_b, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_sum", rsp_sum, 0);
    chk("reset_rsp_cout", rsp_cout, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    req_valid = 4'b0001 << v.id;
    req_a[v.id*16 +: 16] = v.a;
    req_b[v.id*16 +: 16] = v.b;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("vec_ready", req_ready, 4'b0001 << v.id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("vec_add_a", add_a, v.a);
    chk("vec_add_b", add_b, v.b);
    chk("vec_exec_ready", req_ready, 0);
    chk("vec_exec_valid", rsp_valid, 0);
    @(negedge clk); #1;
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, v.id);
    chk("vec_rsp_sum", rsp_sum, v.sum);
    chk("vec_rsp_cout", rsp_cout, v.cout);
    @(negedge clk); #1;
    chk("vec_rsp_done", rsp_valid, 0);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int got, last, n;
    int ptr, phase, mid, win, s;
    bit pend[4];
    logic [15:0] pa[4], pb[4];
    logic [15:0] ma, mb;
    logic [3:0] exp_rdy;
    logic [15:0] fa, fb;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    vecs[0] = '{0, 16'h1234, 16'h0001, 16'h1235, 1'b0};
    vecs[1] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[5] = '{1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Fairness: all four valid from reset, one response every 3 cycles in order 0..3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(16'h1000 * (i + 1) + i);
      req_b[i*16 +: 16] = 16'(16'h0101 * (i + 1));
    end
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    got = 0; last = -1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (rsp_valid) begin
        fa = 16'(16'h1000 * ((got % 4) + 1) + (got % 4));
        fb = 16'(16'h0101 * ((got % 4) + 1));
        chk("fair_id", rsp_id, got % 4);
        chk("fair_sum", rsp_sum, 16'(fa + fb));
        if (got > 0) chk("fair_gap", c - last, 3);
        last = c;
        got++;
      end
      @(negedge clk); #1;
    end
    chk("fair_count", got, 8);

    // Backpressure: response held for 5 cycles, then completes at first ready.
    do_reset();
    req_a[2*16 +: 16] = 16'h0F0F; req_b[2*16 +: 16] = 16'h00F1;
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1 chk("bp_accept", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'b1011;
    #1;
    @(negedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 2);
      chk("bp_sum", rsp_sum, 16'h1000);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_ready", req_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1 chk("bp_still_valid", rsp_valid, 1);
    @(negedge clk); #1;
    chk("bp_done", rsp_valid, 0);
    chk("bp_next_grant", req_ready, 4'b1000);

    // Reset during EXEC discards the op.
    do_reset();
    req_a[1*16 +: 16] = 16'h1111; req_b[1*16 +: 16] = 16'h2222;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1 chk("mid_accept", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1 chk("mid_exec_add_a", add_a, 16'h1111);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'hF;
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_add_a", add_a, 0);
    chk("mid_add_b", add_b, 0);
    chk("mid_grant0", req_ready, 4'b0001);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("mid_no_rsp", rsp_valid, 0);
    end

    // Random traffic against a transaction-level model.
    do_reset();
    ptr = 0; phase = 0; mid = 0; ma = '0; mb = '0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; pa[i] = '0; pb[i] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; pa[i] = rand_op(); pb[i] = rand_op();
        end else if (pend[i] && phase == 0 && $urandom_range(0, 15) == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = pend[i];
        req_a[i*16 +: 16] = pa[i];
        req_b[i*16 +: 16] = pb[i];
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      case (phase)
        0: begin
          win = -1;
          for (int k = 0; k < 4; k++)
            if (win < 0 && pend[(ptr + k) % 4]) win = (ptr + k) % 4;
          exp_rdy = (win < 0) ? 4'b0000 : (4'b0001 << win);
          chk("rnd_ready", req_ready, exp_rdy);
          chk("rnd_idle_valid", rsp_valid, 0);
          if (win >= 0) begin
            ma = pa[win]; mb = pb[win]; mid = win; pend[win] = 0; phase = 1;
          end
        end
        1: begin
          chk("rnd_exec_ready", req_ready, 0);
          chk("rnd_exec_valid", rsp_valid, 0);
          chk("rnd_add_a", add_a, ma);
          chk("rnd_add_b", add_b, mb);
          phase = 2;
        end
        default: begin
          s = int'(ma) + int'(mb);
          chk("rnd_resp_ready", req_ready, 0);
          chk("rnd_rsp_valid", rsp_valid, 1);
          chk("rnd_rsp_id", rsp_id, mid);
          chk("rnd_rsp_sum", rsp_sum, s % 65536);
          chk("rnd_rsp_cout", rsp_cout, s / 65536);
          if (rsp_ready) begin
            ptr = (mid + 1) % 4; phase = 0;
          end
        end
      endcase
      @(negedge clk);
    end
    req_valid = '0;

`ifdef ADDER_ARB_STATS_EN
    do_reset();
    req_a[1*16 +: 16] = 16'h0001; req_b[1*16 +: 16] = 16'h0001;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 1200 && got < 300; c++) begin
      @(negedge clk); #1;
      if (rsp_valid) got++;
    end
    chk("stats_ops", got, 300);
    chk("stats_cnt1", grant_cnt[15:8], 8'hFF);
    chk("stats_others", {grant_cnt[31:16], grant_cnt[7:0]}, 0);
    req_valid = '0;
`endif

    n = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
